// File: rtl/my_design_pkg.sv
// Shared widths, word type and reset value for the add-then-multiply datapath.
package my_design_pkg;

  localparam int unsigned DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t RESET_Y = '0;

endpackage : my_design_pkg

// File: rtl/my_design_add_mul_unit.sv
// Combinational (a + b) * c, keeping only the low DATA_W bits of each stage.
module add_mul_unit
  import my_design_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] prod
);

  word_t sum;

  // Both stages are sized to DATA_W, so carry and upper product bits drop out.
  always_comb begin
    sum  = word_t'(a + b);
    prod = word_t'(sum * c);
  end

endmodule : add_mul_unit

// File: rtl/my_design.sv
// Registered add-then-multiply: y <= (a + b) * c mod 2^32 on each enabled edge.
module my_design
  import my_design_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic              en,
  output logic [DATA_W-1:0] y
);

  word_t prod;

  add_mul_unit u_add_mul_unit (
    .a    (a),
    .b    (b),
    .c    (c),
    .prod (prod)
  );

  // Reset wins over enable; a disabled edge holds the previous result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y <= RESET_Y;
    end else if (en) begin
      y <= prod;
    end
  end

endmodule : my_design

// File: tb/tb_my_design.sv
// Directed and randomized checks of my_design against a 64-bit arithmetic model.
module tb_my_design;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] c;
  logic        en;
  logic [31:0] y;

  int unsigned checks;
  int unsigned errors;
  logic [31:0] model_y;

  my_design dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .en    (en),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result from plain wide arithmetic, reduced modulo 2^32 at each stage.
  function automatic logic [31:0] ref_prod(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic [31:0] rc);
    logic [63:0] s;
    logic [63:0] p;
    s = ({32'd0, ra} + {32'd0, rb}) % 64'h1_0000_0000;
    p = (s * {32'd0, rc}) % 64'h1_0000_0000;
    return p[31:0];
  endfunction

  // Apply one set of inputs across a rising edge, then compare y just after it.
  task automatic step(input logic [31:0] ta, input logic [31:0] tb_v, input logic [31:0] tc,
                      input logic ten, input logic trst_n, input logic [31:0] expected,
                      input string tag);
    a     = ta;
    b     = tb_v;
    c     = tc;
    en    = ten;
    rst_n = trst_n;
    if (!trst_n)  model_y = 32'd0;
    else if (ten) model_y = ref_prod(ta, tb_v, tc);
    @(posedge clk);
    #1;
    checks++;
    assert (y === expected) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, y, expected);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rc;
    logic        ren;
    logic        rrst_n;
    logic [31:0] exp_v;
    checks  = 0;
    errors  = 0;
    model_y = 32'd0;
    rst_n   = 1'b0;
    en      = 1'b0;
    a       = '0;
    b       = '0;
    c       = '0;
    @(negedge clk);

    // Reset held two edges with enable and nonzero operands.
    step(32'd7, 32'd7, 32'd7, 1'b1, 1'b0, 32'd0, "reset_edge1");
    step(32'd7, 32'd7, 32'd7, 1'b1, 1'b0, 32'd0, "reset_edge2");

    // Basic loads, first one on the edge rst_n is first seen high.
    step(32'd10,  32'd20, 32'd3, 1'b1, 1'b1, 32'd90,  "basic_90");
    step(32'd100, 32'd50, 32'd2, 1'b1, 1'b1, 32'd300, "basic_300");
    step(32'd1,   32'd1,  32'd1, 1'b1, 1'b1, 32'd2,   "basic_2");

    // Adder wrap and multiplier truncation.
    step(32'hFFFF_FFFF, 32'd1, 32'd5, 1'b1, 1'b1, 32'h0000_0000, "add_wrap_0");
    step(32'hFFFF_FFFF, 32'd2, 32'd7, 1'b1, 1'b1, 32'd7,         "add_wrap_7");
    step(32'h8000_0000, 32'd0, 32'd3, 1'b1, 1'b1, 32'h8000_0000, "mul_trunc_msb");
    step(32'h0001_0000, 32'd0, 32'h0001_0000, 1'b1, 1'b1, 32'd0, "mul_trunc_zero");

    // Enable hold for three edges, then reload.
    step(32'd10, 32'd20, 32'd3, 1'b1, 1'b1, 32'd90, "hold_load");
    for (int i = 0; i < 3; i++) begin
      step(32'd100, 32'd50, 32'd2, 1'b0, 1'b1, 32'd90, "hold_en0");
    end
    step(32'd100, 32'd50, 32'd2, 1'b1, 1'b1, 32'd300, "hold_reload");

    // Reset asserted mid-stream discards the pending result.
    step(32'd10, 32'd20, 32'd3, 1'b1, 1'b1, 32'd90,  "mid_load1");
    step(32'd1,  32'd2,  32'd3, 1'b1, 1'b1, 32'd9,   "mid_load2");
    step(32'd1,  32'd1,  32'd1, 1'b1, 1'b0, 32'd0,   "mid_reset");
    step(32'd1,  32'd1,  32'd1, 1'b1, 1'b1, 32'd2,   "mid_release");

    // Randomized operands, enable and occasional reset against the model.
    for (int i = 0; i < 300; i++) begin
      ra     = $urandom;
      rb     = $urandom;
      rc     = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) rc = 32'h8000_0000;
      ren    = ($urandom_range(0, 3) != 0);
      rrst_n = ($urandom_range(0, 19) != 0);
      if (!rrst_n)  exp_v = 32'd0;
      else if (ren) exp_v = ref_prod(ra, rb, rc);
      else          exp_v = model_y;
      step(ra, rb, rc, ren, rrst_n, exp_v, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_my_design
